rxuart: RTL and testbench

- 8N1 UART receiver: the receive-side counterpart of the team's txuart. Same bit timing: one bit = CLKS_PER_BIT clk cycles, LSB first, one start bit (0), one stop bit (1), no parity.
- Samples the asynchronous uart_rx pin through a synchroniser and recovers each byte by sampling mid-bit.
- Presents each byte with a one-cycle valid strobe. Reports framing errors.
- Sits at the board UART input, feeding command and LED-pattern logic.

---
 rtl/rxuart_if.sv | 11 +
 rtl/rxuart.sv | 151 +++++++++++++++
 tb/tb_rxuart.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rxuart_if.sv
// Receive-side bundle for rxuart: serial line in, recovered byte and status strobes out.
interface rxuart_if;
  logic       uart_rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport slave  (input uart_rx, output data, valid, frame_err, busy);
  modport master (output uart_rx, input data, valid, frame_err, busy);
endinterface

// File: rtl/rxuart.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, one-cycle valid / frame_err strobes.
// Optional macro RXUART_MAJORITY_EN replaces each single sample with a 2-of-3 vote.
module rxuart #(
  parameter int CLKS_PER_BIT = 217,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input logic      clk,
  input logic      rst,
  rxuart_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [1:0]  sync_q;
  logic        rx_s;
  logic        smp;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  assign rx_s = sync_q[1];

`ifdef RXUART_MAJORITY_EN
  // Decisions land one cycle after the nominal sample point; reloading the
  // counter with 1 keeps later sample points on the same bit grid.
  localparam logic [15:0] START_HIT  = 16'(HALF_BIT);
  localparam logic [15:0] BIT_HIT    = 16'(CLKS_PER_BIT);
  localparam logic [15:0] CNT_RELOAD = 16'd1;

  logic [1:0] vote_q;

  always_ff @(posedge clk) begin
    if (!rst) vote_q <= 2'b11;
    else      vote_q <= {vote_q[0], rx_s};
  end

  assign smp = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
`else
  localparam logic [15:0] START_HIT  = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_HIT    = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_RELOAD = 16'd0;

  assign smp = rx_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = 16'd0;
        end
      end
      START: begin
        if (cnt_q == START_HIT) begin
          if (!smp) begin
            state_d = DATA;
            cnt_d   = CNT_RELOAD;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
            cnt_d   = 16'd0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_HIT) begin
          shift_d[idx_q] = smp;
          cnt_d          = CNT_RELOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_HIT) begin
          cnt_d = 16'd0;
          if (smp) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BREAK: begin
        // A held-low line must not be decoded as a run of 0x00 bytes.
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.uart_rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rxuart.sv
// Self-checking bench for rxuart: directed frames plus random bytes against a queue-based reference.
module tb_rxuart;
  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
`ifdef RXUART_MAJORITY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rxuart_if bus ();

  rxuart #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int fails  = 0;
  int vCount = 0;
  int eCount = 0;
  int bothCount = 0;
  int busyCycles = 0;
  int badBusyAtValid = 0;
  logic prevBusy = 1'b0;
  logic [7:0] rxQ[$];

  // Observer: records every strobe so the main sequence can compare counts.
  always @(negedge clk) begin
    if (bus.valid) begin
      vCount++;
      rxQ.push_back(bus.data);
      if (bus.busy || !prevBusy) badBusyAtValid++;
    end
    if (bus.frame_err) eCount++;
    if (bus.valid && bus.frame_err) bothCount++;
    if (bus.busy) busyCycles++;
    prevBusy = bus.busy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame; glitch inverts a single cycle on each data-bit sample point.
  task automatic applyStimulus(input logic [7:0] b, input logic stopVal, input bit glitch);
    bus.uart_rx = 1'b0;
    tick(CPB);
    for (int k = 0; k < 8; k++) begin
      bus.uart_rx = b[k];
      if (glitch) begin
        tick(4);
        bus.uart_rx = ~b[k];
        tick(1);
        bus.uart_rx = b[k];
        tick(CPB - 5);
      end else begin
        tick(CPB);
      end
    end
    bus.uart_rx = stopVal;
    tick(CPB);
    bus.uart_rx = 1'b1;
  endtask

  initial begin
    logic [7:0] expData;
    logic [7:0] expQ[$];
    logic [7:0] b;
    int v0, e0, q0, bc0, gap;

    bus.uart_rx = 1'b1;
    rst = 1'b0;
    expData = 8'h00;
    tick(3);
    checkOutput("reset_data", {24'd0, bus.data}, 32'h00);
    checkOutput("reset_valid", {31'd0, bus.valid}, 32'd0);
    checkOutput("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b1;
    tick(2);

    v0 = vCount; e0 = eCount;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    tick(3);
    expData = 8'hA5;
    checkOutput("a5_valid_count", vCount - v0, 32'd1);
    checkOutput("a5_data", {24'd0, bus.data}, {24'd0, expData});
    checkOutput("a5_ferr_count", eCount - e0, 32'd0);
    checkOutput("a5_busy_at_valid", badBusyAtValid, 32'd0);

    v0 = vCount; q0 = rxQ.size();
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    tick(3);
    expData = 8'hFF;
    checkOutput("b2b_valid_count", vCount - v0, 32'd2);
    checkOutput("b2b_first", {24'd0, rxQ[q0]}, 32'h00);
    checkOutput("b2b_second", {24'd0, rxQ[q0 + 1]}, 32'hFF);

    v0 = vCount; q0 = rxQ.size();
    expQ.delete();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      gap = $urandom_range(0, 3);
      expQ.push_back(b);
      applyStimulus(b, 1'b1, 1'b0);
      tick(gap);
    end
    tick(3);
    expData = expQ[$];
    checkOutput("rand_valid_count", vCount - v0, 32'd6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("rand_byte%0d", i), {24'd0, rxQ[q0 + i]}, {24'd0, expQ[i]});
    checkOutput("rand_last_data", {24'd0, bus.data}, {24'd0, expData});

    v0 = vCount; e0 = eCount; bc0 = busyCycles;
    bus.uart_rx = 1'b0;
    tick(2);
    bus.uart_rx = 1'b1;
    tick(20);
    checkOutput("glitch_busy_cycles", busyCycles - bc0, HALF + LAG);
    checkOutput("glitch_no_valid", vCount - v0, 32'd0);
    checkOutput("glitch_no_ferr", eCount - e0, 32'd0);

    v0 = vCount; e0 = eCount;
    applyStimulus(8'h3C, 1'b0, 1'b0);
    bus.uart_rx = 1'b0;
    tick(40);
    checkOutput("break_busy_held", {31'd0, bus.busy}, 32'd1);
    checkOutput("break_ferr_count", eCount - e0, 32'd1);
    checkOutput("break_data_kept", {24'd0, bus.data}, {24'd0, expData});
    bus.uart_rx = 1'b1;
    tick(4);
    checkOutput("break_busy_released", {31'd0, bus.busy}, 32'd0);
    tick(10);
    checkOutput("break_no_valid", vCount - v0, 32'd0);
    checkOutput("break_single_ferr", eCount - e0, 32'd1);

    b = 8'($urandom);
    bus.uart_rx = 1'b0;
    tick(CPB);
    for (int k = 0; k < 4; k++) begin
      bus.uart_rx = b[k];
      tick(CPB);
    end
    bus.uart_rx = b[4];
    tick(3);
    rst = 1'b0;
    tick(1);
    expData = 8'h00;
    checkOutput("midreset_data", {24'd0, bus.data}, 32'h00);
    checkOutput("midreset_valid", {31'd0, bus.valid}, 32'd0);
    checkOutput("midreset_ferr", {31'd0, bus.frame_err}, 32'd0);
    checkOutput("midreset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b1;
    bus.uart_rx = 1'b1;
    v0 = vCount;
    tick(20);
    checkOutput("midreset_idle", {31'd0, bus.busy}, 32'd0);
    applyStimulus(8'h5A, 1'b1, 1'b0);
    tick(3);
    expData = 8'h5A;
    checkOutput("after_reset_count", vCount - v0, 32'd1);
    checkOutput("after_reset_data", {24'd0, bus.data}, {24'd0, expData});

`ifdef RXUART_MAJORITY_EN
    v0 = vCount;
    applyStimulus(8'h81, 1'b1, 1'b1);
    tick(3);
    checkOutput("maj_valid_count", vCount - v0, 32'd1);
    checkOutput("maj_data", {24'd0, bus.data}, 32'h81);
`endif

    checkOutput("never_both_strobes", bothCount, 32'd0);
    checkOutput("busy_edge_at_valid", badBusyAtValid, 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
